// File: rtl/snake_body_stream_pkg.sv
// Shared definitions for the snake body streamer: grid size, directions, tile moves.
// Define SNAKE_WRAP_EN to make the grid a torus instead of a walled field.
package snake_body_stream_pkg;

  localparam int GAME_WIDTH  = 18;
  localparam int GAME_HEIGHT = 13;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_MX = 2'd1,
    DIR_PY = 2'd2,
    DIR_MY = 2'd3
  } dir_t;

  typedef enum logic {
    ST_GAP    = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } tile_t;

  localparam tile_t HOME_TILE = '{x: 5'(GAME_WIDTH / 2 + 1), y: 4'(GAME_HEIGHT / 2 + 1)};

  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  function automatic tile_t move_tile(input logic [4:0] x, input logic [3:0] y, input dir_t d);
    tile_t t;
    t.x = x;
    t.y = y;
    case (d)
`ifdef SNAKE_WRAP_EN
      DIR_PX: t.x = (x == 5'(GAME_WIDTH)) ? 5'd1 : x + 5'd1;
      DIR_MX: t.x = (x == 5'd1) ? 5'(GAME_WIDTH) : x - 5'd1;
      DIR_PY: t.y = (y == 4'(GAME_HEIGHT)) ? 4'd1 : y + 4'd1;
      DIR_MY: t.y = (y == 4'd1) ? 4'(GAME_HEIGHT) : y - 4'd1;
`else
      DIR_PX: t.x = x + 5'd1;
      DIR_MX: t.x = x - 5'd1;
      DIR_PY: t.y = y + 4'd1;
      DIR_MY: t.y = y - 4'd1;
`endif
      default: ;
    endcase
    return t;
  endfunction

  // The playfield is 1..GAME_WIDTH x 1..GAME_HEIGHT; the ring around it is the wall.
  function automatic logic is_wall(input tile_t t);
    return (t.x == 5'd0) || (t.x == 5'(GAME_WIDTH + 1)) ||
           (t.y == 4'd0) || (t.y == 4'(GAME_HEIGHT + 1));
  endfunction

endpackage

// File: rtl/snake_body_stream_if.sv
// Step request handshake from the game controller plus the body stream to the renderer.
interface snake_body_stream_if #(
  parameter int MAX_LENGTH = 64
);
  localparam int LW = $clog2(MAX_LENGTH) + 1;

  logic          step_valid;
  logic          step_ready;
  logic [1:0]    step_dir;
  logic          step_grow;
  logic [4:0]    snake_head_x;
  logic [3:0]    snake_head_y;
  logic [4:0]    snake_x;
  logic [3:0]    snake_y;
  logic [1:0]    snake_dir;
  logic          snake_first;
  logic          snake_last;
  logic          snake_valid;
  logic [LW-1:0] length;
  logic          failure;
  logic          success;

  modport master (
    output step_valid, step_dir, step_grow,
    input  step_ready, snake_head_x, snake_head_y, snake_x, snake_y, snake_dir,
    input  snake_first, snake_last, snake_valid, length, failure, success
  );

  modport slave (
    input  step_valid, step_dir, step_grow,
    output step_ready, snake_head_x, snake_head_y, snake_x, snake_y, snake_dir,
    output snake_first, snake_last, snake_valid, length, failure, success
  );

endinterface

// File: rtl/snake_dir_ram.sv
// Ring buffer of 2-bit body links: one synchronous write port, one asynchronous read port.
module snake_dir_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [1:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [1:0]               rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/snake_body_stream.sv
// Holds the snake as head + link ring and streams it head-to-tail, one segment per clock.
// SNAKE_WRAP_EN selects a toroidal grid (no wall collision).
module snake_body_stream
  import snake_body_stream_pkg::*;
#(
  parameter int MAX_LENGTH  = 64,
  parameter int INIT_LENGTH = 3
) (
  input logic                clk,
  input logic                rst,
  input logic                game_rst_n,
  snake_body_stream_if.slave bus
);

  localparam int PW = $clog2(MAX_LENGTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_LENGTH);
  localparam logic [LW-1:0] INIT_LEN = LW'(INIT_LENGTH);

  state_t        state_reg;
  logic [PW-1:0] head_ptr_reg;
  logic [LW-1:0] written_reg;
  logic [LW-1:0] length_reg;
  logic [PW-1:0] seg_idx_reg;
  tile_t         head_reg;
  tile_t         seg_reg;
  dir_t          seg_dir_reg;
  logic          valid_reg;
  logic          first_reg;
  logic          last_reg;
  logic          ready_reg;
  logic          failure_reg;
  logic          success_reg;

  logic          step_fire;
  tile_t         step_tile;
  dir_t          step_link;
  logic [PW-1:0] head_ptr_next;
  logic [LW-1:0] length_next;
  logic [PW-1:0] seg_idx_inc;
  logic [PW-1:0] rel_idx;
  logic [PW-1:0] ram_raddr;
  logic [1:0]    ram_rdata;
  dir_t          link_rd;
  tile_t         walk_tile;
  logic          self_hit;
  logic          failure_set;

  assign step_fire     = bus.step_valid && ready_reg && (state_reg == ST_GAP);
  assign step_tile     = move_tile(head_reg.x, head_reg.y, dir_t'(bus.step_dir));
  assign step_link     = opposite_dir(dir_t'(bus.step_dir));
  assign head_ptr_next = step_fire ? head_ptr_reg - 1'b1 : head_ptr_reg;
  assign length_next   = (step_fire && bus.step_grow && (length_reg != MAX_LEN)) ?
                         length_reg + 1'b1 : length_reg;

  // In GAP the walker prepares segment 0; in STREAM it prepares the segment after the shown one.
  assign seg_idx_inc = seg_idx_reg + 1'b1;
  assign rel_idx     = (state_reg == ST_GAP) ? '0 : seg_idx_inc;
  assign ram_raddr   = head_ptr_reg + rel_idx;

  // Links never written since restart are still the initial -x body, so the RAM needs no clear.
  assign link_rd   = ({1'b0, rel_idx} < written_reg) ? dir_t'(ram_rdata) : DIR_MX;
  assign walk_tile = move_tile(seg_reg.x, seg_reg.y, seg_dir_reg);
  assign self_hit  = valid_reg && !first_reg && (seg_reg == head_reg);

`ifdef SNAKE_WRAP_EN
  assign failure_set = self_hit;
`else
  assign failure_set = self_hit || (step_fire && is_wall(step_tile));
`endif

  snake_dir_ram #(
    .DEPTH (MAX_LENGTH)
  ) u_dir_ram (
    .clk   (clk),
    .we    (step_fire),
    .waddr (head_ptr_next),
    .wdata (step_link),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_GAP;
      head_ptr_reg <= '0;
      written_reg  <= '0;
      length_reg   <= INIT_LEN;
      seg_idx_reg  <= '0;
      head_reg     <= HOME_TILE;
      seg_reg      <= '0;
      seg_dir_reg  <= DIR_PX;
      valid_reg    <= 1'b0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      failure_reg  <= 1'b0;
      success_reg  <= 1'b0;
    end else if (!game_rst_n) begin
      state_reg   <= ST_GAP;
      written_reg <= '0;
      length_reg  <= INIT_LEN;
      seg_idx_reg <= '0;
      head_reg    <= HOME_TILE;
      valid_reg   <= 1'b0;
      first_reg   <= 1'b0;
      last_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      failure_reg <= 1'b0;
      success_reg <= (INIT_LEN == MAX_LEN);
    end else begin
      failure_reg  <= failure_reg | failure_set;
      success_reg  <= success_reg | (length_next == MAX_LEN);
      length_reg   <= length_next;
      head_ptr_reg <= head_ptr_next;
      if (step_fire) begin
        head_reg <= step_tile;
        if (written_reg != MAX_LEN) begin
          written_reg <= written_reg + 1'b1;
        end
      end
      case (state_reg)
        ST_GAP: begin
          // A step taken now is already part of the pass that starts next cycle.
          state_reg   <= ST_STREAM;
          ready_reg   <= 1'b0;
          valid_reg   <= 1'b1;
          first_reg   <= 1'b1;
          last_reg    <= (length_next == LW'(1));
          seg_idx_reg <= '0;
          seg_reg     <= step_fire ? step_tile : head_reg;
          seg_dir_reg <= step_fire ? step_link : link_rd;
        end
        default: begin
          if (last_reg) begin
            state_reg <= ST_GAP;
            valid_reg <= 1'b0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            ready_reg <= !(failure_reg || failure_set);
          end else begin
            seg_idx_reg <= seg_idx_inc;
            seg_reg     <= walk_tile;
            seg_dir_reg <= link_rd;
            first_reg   <= 1'b0;
            last_reg    <= ({1'b0, seg_idx_inc} == (length_reg - 1'b1));
          end
        end
      endcase
    end
  end

  assign bus.step_ready   = ready_reg;
  assign bus.snake_head_x = head_reg.x;
  assign bus.snake_head_y = head_reg.y;
  assign bus.snake_x      = seg_reg.x;
  assign bus.snake_y      = seg_reg.y;
  assign bus.snake_dir    = seg_dir_reg;
  assign bus.snake_first  = first_reg;
  assign bus.snake_last   = last_reg;
  assign bus.snake_valid  = valid_reg;
  assign bus.length       = length_reg;
  assign bus.failure      = failure_reg;
  assign bus.success      = success_reg;

endmodule

// File: tb/tb_snake_body_stream.sv
// Directed bench for snake_body_stream with an 8-deep ring and a 3-segment start.
module tb_snake_body_stream;

  localparam int MAXL = 8;

  logic clk = 1'b0;
  logic rst;
  logic game_rst_n;

  int checks = 0;
  int errors = 0;

  logic [10:0] cap_seg [16];
  int          cap_n;

  snake_body_stream_if #(.MAX_LENGTH(MAXL)) bus ();

  snake_body_stream #(
    .MAX_LENGTH  (MAXL),
    .INIT_LENGTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_rst_n (game_rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] pk(input int x, input int y, input int d);
    return {5'(x), 4'(y), 2'(d)};
  endfunction

  // Drive one step request and hold it until the design takes it; returns on segment 0.
  task automatic do_step(input logic [1:0] d, input logic g);
    int n;
    @(negedge clk);
    bus.step_valid = 1'b1;
    bus.step_dir   = d;
    bus.step_grow  = g;
    n = 0;
    while (bus.step_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL step_wait step_ready never rose within 100 cycles");
    end
    @(negedge clk);
    bus.step_valid = 1'b0;
  endtask

  // Record one full pass starting at the next (or current) segment 0.
  task automatic capture_pass();
    int n;
    n = 0;
    cap_n = 0;
    for (int i = 0; i < 16; i++) cap_seg[i] = '1;
    while (!(bus.snake_valid === 1'b1 && bus.snake_first === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL pass_start no segment 0 within 100 cycles");
      return;
    end
    while (cap_n < 16) begin
      cap_seg[cap_n] = {bus.snake_x, bus.snake_y, bus.snake_dir};
      cap_n++;
      if (bus.snake_last === 1'b1) break;
      @(negedge clk);
      if (bus.snake_valid !== 1'b1) break;
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    game_rst_n = 1'b0;
    @(negedge clk);
    game_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_rst_n = 1'b1;
    bus.step_valid = 1'b0;
    bus.step_dir = 2'd0;
    bus.step_grow = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.snake_valid, bus.snake_first, bus.snake_last, bus.step_ready, bus.failure, bus.success} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got v%b f%b l%b r%b fail%b s%b want all 0", bus.snake_valid, bus.snake_first,
               bus.snake_last, bus.step_ready, bus.failure, bus.success);
    end
    checks++;
    if ({bus.snake_x, bus.snake_y, bus.snake_dir} !== 11'd0) begin
      errors++;
      $display("FAIL reset_seg got (%0d,%0d,d%0d) want (0,0,d0)", bus.snake_x, bus.snake_y, bus.snake_dir);
    end
    checks++;
    if (bus.snake_head_x !== 5'd10 || bus.snake_head_y !== 4'd7 || bus.length !== 4'd3) begin
      errors++;
      $display("FAIL reset_head got (%0d,%0d) len %0d want (10,7) len 3", bus.snake_head_x, bus.snake_head_y, bus.length);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.snake_valid, bus.snake_first, bus.snake_last} !== 3'b110 || {bus.snake_x, bus.snake_y, bus.snake_dir} !== pk(10, 7, 1)) begin
      errors++;
      $display("FAIL reset_seg0 got (%0d,%0d,d%0d) vfl %b%b%b want (10,7,d1) vfl 110", bus.snake_x, bus.snake_y,
               bus.snake_dir, bus.snake_valid, bus.snake_first, bus.snake_last);
    end
    @(negedge clk);
    checks++;
    if ({bus.snake_valid, bus.snake_first, bus.snake_last} !== 3'b100 || {bus.snake_x, bus.snake_y, bus.snake_dir} !== pk(9, 7, 1)) begin
      errors++;
      $display("FAIL reset_seg1 got (%0d,%0d,d%0d) vfl %b%b%b want (9,7,d1) vfl 100", bus.snake_x, bus.snake_y,
               bus.snake_dir, bus.snake_valid, bus.snake_first, bus.snake_last);
    end
    @(negedge clk);
    checks++;
    if ({bus.snake_valid, bus.snake_first, bus.snake_last} !== 3'b101 || {bus.snake_x, bus.snake_y, bus.snake_dir} !== pk(8, 7, 1)) begin
      errors++;
      $display("FAIL reset_seg2 got (%0d,%0d,d%0d) vfl %b%b%b want (8,7,d1) vfl 101", bus.snake_x, bus.snake_y,
               bus.snake_dir, bus.snake_valid, bus.snake_first, bus.snake_last);
    end
    @(negedge clk);
    checks++;
    if (bus.snake_valid !== 1'b0 || bus.step_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_gap got valid %b ready %b want valid 0 ready 1", bus.snake_valid, bus.step_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.snake_valid !== 1'b1 || bus.snake_first !== 1'b1) begin
      errors++;
      $display("FAIL reset_period got valid %b first %b want 1 1 (period 4)", bus.snake_valid, bus.snake_first);
    end
  endtask

  task automatic test_step_move();
    logic [10:0] exp [3];
    exp = '{pk(10, 8, 3), pk(10, 7, 1), pk(9, 7, 1)};
    do_step(2'd2, 1'b0);
    checks++;
    if (bus.snake_head_x !== 5'd10 || bus.snake_head_y !== 4'd8 || bus.length !== 4'd3) begin
      errors++;
      $display("FAIL move_head got (%0d,%0d) len %0d want (10,8) len 3", bus.snake_head_x, bus.snake_head_y, bus.length);
    end
    capture_pass();
    checks++;
    if (cap_n != 3) begin
      errors++;
      $display("FAIL move_count got %0d want 3", cap_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_seg[i] !== exp[i]) begin
        errors++;
        $display("FAIL move_seg%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)", i, cap_seg[i][10:6], cap_seg[i][5:2],
                 cap_seg[i][1:0], exp[i][10:6], exp[i][5:2], exp[i][1:0]);
      end
    end
  endtask

  task automatic test_grow();
    logic [10:0] exp4 [4];
    logic [10:0] exp6 [6];
    int n;
    exp4 = '{pk(11, 8, 1), pk(10, 8, 3), pk(10, 7, 1), pk(9, 7, 1)};
    exp6 = '{pk(13, 8, 1), pk(12, 8, 1), pk(11, 8, 1), pk(10, 8, 3), pk(10, 7, 1), pk(9, 7, 1)};
    n = 0;
    while (!(bus.snake_valid === 1'b1 && bus.snake_first === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    // Raise the request mid-pass: it must wait for GAP and be taken exactly once.
    bus.step_valid = 1'b1;
    bus.step_dir = 2'd0;
    bus.step_grow = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.length !== 4'd3 || bus.snake_head_x !== 5'd10 || bus.step_ready !== 1'b0) begin
      errors++;
      $display("FAIL grow_wait got len %0d head_x %0d ready %b want 3 10 0", bus.length, bus.snake_head_x, bus.step_ready);
    end
    do_step(2'd0, 1'b1);
    checks++;
    if (bus.length !== 4'd4 || bus.snake_head_x !== 5'd11 || bus.snake_head_y !== 4'd8) begin
      errors++;
      $display("FAIL grow_once got len %0d head (%0d,%0d) want 4 (11,8)", bus.length, bus.snake_head_x, bus.snake_head_y);
    end
    capture_pass();
    checks++;
    if (cap_n != 4) begin
      errors++;
      $display("FAIL grow4_count got %0d want 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_seg[i] !== exp4[i]) begin
        errors++;
        $display("FAIL grow4_seg%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)", i, cap_seg[i][10:6], cap_seg[i][5:2],
                 cap_seg[i][1:0], exp4[i][10:6], exp4[i][5:2], exp4[i][1:0]);
      end
    end
    do_step(2'd0, 1'b1);
    do_step(2'd0, 1'b1);
    checks++;
    if (bus.length !== 4'd6) begin
      errors++;
      $display("FAIL grow_len got %0d want 6", bus.length);
    end
    capture_pass();
    checks++;
    if (cap_n != 6) begin
      errors++;
      $display("FAIL grow6_count got %0d want 6", cap_n);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_seg[i] !== exp6[i]) begin
        errors++;
        $display("FAIL grow6_seg%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)", i, cap_seg[i][10:6], cap_seg[i][5:2],
                 cap_seg[i][1:0], exp6[i][10:6], exp6[i][5:2], exp6[i][1:0]);
      end
    end
  endtask

  task automatic test_self_collision();
    int n;
    do_step(2'd2, 1'b0);
    do_step(2'd1, 1'b0);
    checks++;
    if (bus.failure !== 1'b0) begin
      errors++;
      $display("FAIL coll_early got failure %b want 0", bus.failure);
    end
    do_step(2'd3, 1'b0);
    checks++;
    if (bus.snake_head_x !== 5'd12 || bus.snake_head_y !== 4'd8 || bus.failure !== 1'b0) begin
      errors++;
      $display("FAIL coll_head got (%0d,%0d) failure %b want (12,8) 0", bus.snake_head_x, bus.snake_head_y, bus.failure);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.snake_x !== 5'd12 || bus.snake_y !== 4'd8 || bus.failure !== 1'b0) begin
      errors++;
      $display("FAIL coll_seg4 got (%0d,%0d) failure %b want (12,8) 0", bus.snake_x, bus.snake_y, bus.failure);
    end
    @(negedge clk);
    checks++;
    if (bus.failure !== 1'b1 || bus.snake_x !== 5'd11 || bus.snake_last !== 1'b1) begin
      errors++;
      $display("FAIL coll_rise got failure %b x %0d last %b want 1 11 1", bus.failure, bus.snake_x, bus.snake_last);
    end
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.snake_valid !== 1'b0 && n < 100);
      checks++;
      if (bus.step_ready !== 1'b0 || n >= 100) begin
        errors++;
        $display("FAIL coll_ready gap%0d got ready %b wait %0d want ready 0", p, bus.step_ready, n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wall();
    pulse_restart();
    checks++;
    if (bus.failure !== 1'b0 || bus.length !== 4'd3 || bus.snake_head_x !== 5'd10 || bus.snake_valid !== 1'b0) begin
      errors++;
      $display("FAIL wall_restart got failure %b len %0d head_x %0d valid %b want 0 3 10 0", bus.failure, bus.length,
               bus.snake_head_x, bus.snake_valid);
    end
    do_step(2'd2, 1'b0);
    for (int i = 0; i < 9; i++) do_step(2'd1, 1'b0);
    checks++;
    if (bus.snake_head_x !== 5'd1 || bus.snake_head_y !== 4'd8 || bus.failure !== 1'b0) begin
      errors++;
      $display("FAIL wall_edge got (%0d,%0d) failure %b want (1,8) 0", bus.snake_head_x, bus.snake_head_y, bus.failure);
    end
    do_step(2'd1, 1'b0);
`ifdef SNAKE_WRAP_EN
    checks++;
    if (bus.snake_head_x !== 5'd18 || bus.failure !== 1'b0) begin
      errors++;
      $display("FAIL wall_cross got head_x %0d failure %b want 18 0", bus.snake_head_x, bus.failure);
    end
`else
    checks++;
    if (bus.snake_head_x !== 5'd0 || bus.failure !== 1'b1) begin
      errors++;
      $display("FAIL wall_cross got head_x %0d failure %b want 0 1", bus.snake_head_x, bus.failure);
    end
`endif
    capture_pass();
    checks++;
    if (cap_n != 3 || cap_seg[1][10:2] !== {5'd1, 4'd8}) begin
      errors++;
      $display("FAIL wall_seg1 got count %0d (%0d,%0d) want 3 (1,8)", cap_n, cap_seg[1][10:6], cap_seg[1][5:2]);
    end
  endtask

  task automatic test_grow_full();
    logic [10:0] exp [8];
    exp = '{pk(11, 12, 1), pk(10, 12, 3), pk(10, 11, 3), pk(10, 10, 3), pk(10, 9, 3), pk(10, 8, 3), pk(10, 7, 1), pk(9, 7, 1)};
    pulse_restart();
    checks++;
    if (bus.failure !== 1'b0 || bus.success !== 1'b0) begin
      errors++;
      $display("FAIL full_restart got failure %b success %b want 0 0", bus.failure, bus.success);
    end
    for (int i = 0; i < 4; i++) do_step(2'd2, 1'b1);
    checks++;
    if (bus.length !== 4'd7 || bus.success !== 1'b0) begin
      errors++;
      $display("FAIL full_pre got len %0d success %b want 7 0", bus.length, bus.success);
    end
    do_step(2'd2, 1'b1);
    checks++;
    if (bus.length !== 4'd8 || bus.success !== 1'b1) begin
      errors++;
      $display("FAIL full_hit got len %0d success %b want 8 1", bus.length, bus.success);
    end
    do_step(2'd0, 1'b1);
    checks++;
    if (bus.length !== 4'd8 || bus.success !== 1'b1 || bus.snake_head_x !== 5'd11 || bus.snake_head_y !== 4'd12) begin
      errors++;
      $display("FAIL full_extra got len %0d success %b head (%0d,%0d) want 8 1 (11,12)", bus.length, bus.success,
               bus.snake_head_x, bus.snake_head_y);
    end
    capture_pass();
    checks++;
    if (cap_n != 8) begin
      errors++;
      $display("FAIL full_count got %0d want 8", cap_n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp[i]) begin
        errors++;
        $display("FAIL full_seg%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)", i, cap_seg[i][10:6], cap_seg[i][5:2],
                 cap_seg[i][1:0], exp[i][10:6], exp[i][5:2], exp[i][1:0]);
      end
    end
  endtask

  task automatic test_restart();
    logic [10:0] exp [3];
    exp = '{pk(10, 7, 1), pk(9, 7, 1), pk(8, 7, 1)};
    pulse_restart();
    checks++;
    if (bus.length !== 4'd3 || bus.success !== 1'b0 || bus.failure !== 1'b0 ||
        bus.snake_head_x !== 5'd10 || bus.snake_head_y !== 4'd7) begin
      errors++;
      $display("FAIL restart_state got len %0d s %b f %b head (%0d,%0d) want 3 0 0 (10,7)", bus.length, bus.success,
               bus.failure, bus.snake_head_x, bus.snake_head_y);
    end
    capture_pass();
    checks++;
    if (cap_n != 3 || cap_seg[0] !== exp[0] || cap_seg[1] !== exp[1] || cap_seg[2] !== exp[2]) begin
      errors++;
      $display("FAIL restart_pass got n %0d tail (%0d,%0d) want 3 (8,7)", cap_n, cap_seg[2][10:6], cap_seg[2][5:2]);
    end
    do_step(2'd2, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.snake_valid !== 1'b0 || bus.length !== 4'd3 || bus.snake_head_y !== 4'd7 || bus.step_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort got valid %b len %0d head_y %0d ready %b want 0 3 7 0", bus.snake_valid, bus.length,
               bus.snake_head_y, bus.step_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    capture_pass();
    checks++;
    if (cap_n != 3 || cap_seg[0] !== exp[0] || cap_seg[2] !== exp[2]) begin
      errors++;
      $display("FAIL rst_pass got n %0d head (%0d,%0d) want 3 (10,7)", cap_n, cap_seg[0][10:6], cap_seg[0][5:2]);
    end
  endtask

  initial begin
    test_reset();
    test_step_move();
    test_grow();
    test_self_collision();
    test_wall();
    test_grow_full();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
